id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32 core, directly upstream of the ALU.
- Captures decoded operands and control at the decode/execute boundary and applies EX/MEM and MEM/WB forwarding.
- Drives the ALU's operand A, operand B and 3-bit operation inputs.
- Detects load-use hazards and inserts a bubble; honours pipeline stall and flush.

---
 rtl/core_pkg.sv | 28 ++
 rtl/fwd_unit.sv | 53 +++++
 rtl/id_ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 core pipeline:
//   - XLEN / RA_W    : datapath and register-address widths
//   - ALU_*          : 3-bit ALU operation codes
//   - fwd_sel_e      : operand forwarding source select
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXM = 2'b01,
    FWD_MWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Combinational forwarding select and mux for one source operand.
// Ports:
//   rs            : source register address held in the ID/EX register
//   rf_data       : register-file data captured with that instruction
//   exm_reg_write, exm_rd, exm_result : EX/MEM writeback candidate
//   mwb_reg_write, mwb_rd, mwb_data   : MEM/WB writeback candidate
//   fwd_data      : selected operand value
// EX/MEM is the younger result, so it wins over MEM/WB. x0 never forwards.
// ---------------------------------------------------------------------------
module fwd_unit
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] fwd_data
);

  function automatic logic fwd_hit(input logic we, input logic [RA_W-1:0] rd,
                                   input logic [RA_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (fwd_hit(exm_reg_write, exm_rd, rs))
      sel = FWD_EXM;
    else if (fwd_hit(mwb_reg_write, mwb_rd, rs))
      sel = FWD_MWB;
  end

  always_comb begin
    fwd_data = rf_data;
    case (sel)
      FWD_EXM: fwd_data = exm_result;
      FWD_MWB: fwd_data = mwb_data;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage RV32 core, feeding the ALU.
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   stall_in          : hold all register contents (memory wait)
//   flush_in          : load a bubble (branch/jump redirect), beats stall_in
//   id_*              : decoded instruction fields from the decode stage
//   exm_*, mwb_*      : EX/MEM and MEM/WB writeback candidates for forwarding
//   alu_a, alu_b      : forwarded ALU operands (combinational from state)
//   alu_op            : registered ALU op code
//   ex_store_data     : forwarded rs2 for stores, regardless of alu_src
//   ex_*              : registered copies of the ID control/PC/rd fields
//   hazard_stall      : load-use detected; upstream holds PC and IF/ID
// ---------------------------------------------------------------------------
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_uses_rs2,
  input  logic [2:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            hazard_stall
);

  logic            vld_p1;
  logic [XLEN-1:0] pc_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [XLEN-1:0] imm_p1;
  logic [RA_W-1:0] rs1_p1;
  logic [RA_W-1:0] rs2_p1;
  logic [RA_W-1:0] rd_p1;
  logic [2:0]      alu_op_p1;
  logic            alu_src_p1;
  logic            reg_write_p1;
  logic            mem_read_p1;
  logic            mem_write_p1;
  logic            branch_p1;

  logic            hold;
  logic            bubble;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX whose rd feeds the decoding instruction cannot forward in
  // time; the consumer waits one cycle while a bubble goes down the pipe.
  assign hazard_stall = id_valid && vld_p1 && mem_read_p1 && (rd_p1 != '0) &&
                        ((id_rs1 == rd_p1) || (id_uses_rs2 && (id_rs2 == rd_p1)));

  // flush beats stall; stall beats the load-use bubble (hazard_stall still
  // reported so upstream keeps holding).
  assign hold   = stall_in && !flush_in;
  assign bubble = flush_in || hazard_stall;

  // ---- ID -> EX register boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      alu_op_p1    <= ALU_ADD;
      alu_src_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      branch_p1    <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        vld_p1       <= 1'b0;
        pc_p1        <= '0;
        rs1_data_p1  <= '0;
        rs2_data_p1  <= '0;
        imm_p1       <= '0;
        rs1_p1       <= '0;
        rs2_p1       <= '0;
        rd_p1        <= '0;
        alu_op_p1    <= ALU_ADD;
        alu_src_p1   <= 1'b0;
        reg_write_p1 <= 1'b0;
        mem_read_p1  <= 1'b0;
        mem_write_p1 <= 1'b0;
        branch_p1    <= 1'b0;
      end else begin
        vld_p1       <= id_valid;
        pc_p1        <= id_pc;
        rs1_data_p1  <= id_rs1_data;
        rs2_data_p1  <= id_rs2_data;
        imm_p1       <= id_imm;
        rs1_p1       <= id_rs1;
        rs2_p1       <= id_rs2;
        rd_p1        <= id_rd;
        alu_op_p1    <= id_alu_op;
        alu_src_p1   <= id_alu_src;
        reg_write_p1 <= id_reg_write;
        mem_read_p1  <= id_mem_read;
        mem_write_p1 <= id_mem_write;
        branch_p1    <= id_branch;
      end
    end
  end

  // ---- EX: forwarding and operand selection ----
  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs            (rs1_p1),
    .rf_data       (rs1_data_p1),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .fwd_data      (fwd_rs1)
  );

  fwd_unit #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs            (rs2_p1),
    .rf_data       (rs2_data_p1),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_data      (mwb_data),
    .fwd_data      (fwd_rs2)
  );

  assign alu_a         = fwd_rs1;
  assign alu_b         = alu_src_p1 ? imm_p1 : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign alu_op        = alu_op_p1;
  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_branch     = branch_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a driver applies one stimulus per cycle at the
// falling edge and pushes the reference model's expected outputs; a monitor
// samples the DUT shortly after and compares against the queue head.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, flush_in, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs2;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [2:0]  alu_op;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [4:0]  ex_rd;
  logic        hazard_stall;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .hazard_stall(hazard_stall)
  );

  typedef struct packed {
    logic        flush, stall, valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        u2;
    logic [2:0]  op;
    logic        src, rw, mr, mw, br;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwd;
  } stim_t;

  // Instruction sitting in the EX slot, as the model sees it.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  op;
    logic        src, rw, mr, mw, br;
  } slot_t;

  typedef struct packed {
    logic [31:0] a, b, sd, pc;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        valid, rw, mr, mw, br, hz;
  } exp_t;

  slot_t model;
  exp_t  expq[$];
  int    passed = 0;
  int    total  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf, input stim_t s);
    if (s.exw && s.exrd != 0 && s.exrd == rs) return s.exres;
    if (s.mww && s.mwrd != 0 && s.mwrd == rs) return s.mwd;
    return rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.flush = ($urandom_range(9) == 0);
    s.stall = ($urandom_range(5) == 0);
    s.valid = ($urandom_range(4) != 0);
    s.pc    = $urandom & 32'hFFFF_FFFC;
    s.rs1d  = $urandom;
    s.rs2d  = $urandom;
    s.imm   = $urandom;
    s.rs1   = 5'($urandom_range(7));
    s.rs2   = 5'($urandom_range(7));
    s.rd    = 5'($urandom_range(7));
    s.u2    = 1'($urandom);
    s.op    = 3'($urandom);
    s.src   = 1'($urandom);
    s.rw    = 1'($urandom);
    s.mr    = ($urandom_range(2) == 0);
    s.mw    = 1'($urandom);
    s.br    = 1'($urandom);
    s.exw   = 1'($urandom);
    s.exrd  = 5'($urandom_range(7));
    s.exres = $urandom;
    s.mww   = 1'($urandom);
    s.mwrd  = 5'($urandom_range(7));
    s.mwd   = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    flush_in = s.flush; stall_in = s.stall; id_valid = s.valid;
    id_pc = s.pc; id_rs1_data = s.rs1d; id_rs2_data = s.rs2d; id_imm = s.imm;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; id_uses_rs2 = s.u2;
    id_alu_op = s.op; id_alu_src = s.src; id_reg_write = s.rw;
    id_mem_read = s.mr; id_mem_write = s.mw; id_branch = s.br;
    exm_reg_write = s.exw; exm_rd = s.exrd; exm_result = s.exres;
    mwb_reg_write = s.mww; mwb_rd = s.mwrd; mwb_data = s.mwd;
  endtask

  // One cycle: drive at the falling edge, predict what the DUT shows before
  // the next rising edge, then advance the model across that edge.
  task automatic drive(input stim_t s);
    exp_t  e;
    logic  hz;
    logic [31:0] f2;
    @(negedge clk);
    apply(s);
    hz = s.valid && model.valid && model.mr && model.rd != 0 &&
         (s.rs1 == model.rd || (s.u2 && s.rs2 == model.rd));
    f2      = fwd(model.rs2, model.rs2d, s);
    e.a     = fwd(model.rs1, model.rs1d, s);
    e.b     = model.src ? model.imm : f2;
    e.sd    = f2;
    e.pc    = model.pc;
    e.op    = model.op;
    e.rd    = model.rd;
    e.valid = model.valid;
    e.rw    = model.rw;
    e.mr    = model.mr;
    e.mw    = model.mw;
    e.br    = model.br;
    e.hz    = hz;
    expq.push_back(e);
    if (s.flush)       model = '0;
    else if (s.stall)  model = model;
    else if (hz)       model = '0;
    else model = '{s.valid, s.pc, s.rs1d, s.rs2d, s.imm, s.rs1, s.rs2, s.rd,
                   s.op, s.src, s.rw, s.mr, s.mw, s.br};
    #2;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("alu_a", alu_a, e.a);
        check("alu_b", alu_b, e.b);
        check("ex_store_data", ex_store_data, e.sd);
        check("alu_op", {29'd0, alu_op}, {29'd0, e.op});
        check("ex_pc", ex_pc, e.pc);
        check("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
        check("ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
                      {27'd0, e.valid, e.rw, e.mr, e.mw, e.br});
        check("hazard_stall", {31'd0, hazard_stall}, {31'd0, e.hz});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    n;
    model = '0;
    rst = 1'b1;
    apply(idle());
    #3;
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst alu_op", {29'd0, alu_op}, 32'd0);
    check("rst ex_pc", ex_pc, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain load
    s = idle(); s.valid = 1; s.rs1d = 5; s.imm = 7; s.src = 1; s.rs1 = 1; s.rd = 2;
    drive(s);
    drive(idle());
    check("plain alu_a", alu_a, 32'd5);
    check("plain alu_b", alu_b, 32'd7);

    // Forward priority, EX contents held by stall
    s = idle(); s.valid = 1; s.rs1 = 3; s.rs1d = 32'h11; s.rd = 8; s.rw = 1;
    drive(s);
    s = idle(); s.stall = 1; s.exw = 1; s.exrd = 3; s.exres = 32'hAA;
    s.mww = 1; s.mwrd = 3; s.mwd = 32'hBB;
    drive(s);
    check("fwd exm prio", alu_a, 32'hAA);
    s.exw = 0;
    drive(s);
    check("fwd mwb", alu_a, 32'hBB);
    s.exw = 1; s.exrd = 0; s.mwrd = 0;
    drive(s);
    check("fwd x0 rf", alu_a, 32'h11);

    // Load-use
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.rd = 4; s.rs1 = 1;
    drive(s);
    s = idle(); s.valid = 1; s.rs1 = 1; s.rs2 = 4; s.u2 = 1; s.rw = 1; s.rd = 5;
    drive(s);
    check("loaduse hazard", {31'd0, hazard_stall}, 32'd1);
    drive(s);
    check("loaduse bubble valid", {31'd0, ex_valid}, 32'd0);
    check("loaduse bubble rw", {31'd0, ex_reg_write}, 32'd0);
    drive(idle());
    check("loaduse add enters", {27'd0, ex_rd}, 32'd5);

    // Flush beats stall; stall alone holds
    s = idle(); s.valid = 1; s.rd = 7; s.rw = 1;
    drive(s);
    s.flush = 1; s.stall = 1;
    drive(s);
    drive(idle());
    check("flush+stall bubble", {31'd0, ex_valid}, 32'd0);
    s = idle(); s.valid = 1; s.rd = 9; s.pc = 32'h100; s.br = 1;
    drive(s);
    s = idle(); s.stall = 1; s.valid = 1; s.rd = 12;
    for (int i = 0; i < 3; i++) begin
      drive(s);
      check("stall hold rd", {27'd0, ex_rd}, 32'd9);
      check("stall hold pc", ex_pc, 32'h100);
    end

    // Store forwarding
    s = idle(); s.valid = 1; s.mw = 1; s.src = 1; s.imm = 32'h40; s.rs2 = 6;
    s.rs2d = 32'h99; s.u2 = 1;
    drive(s);
    s = idle(); s.mww = 1; s.mwrd = 6; s.mwd = 32'h1234;
    drive(s);
    check("store data fwd", ex_store_data, 32'h1234);
    check("store alu_b imm", alu_b, 32'h40);

    // Randomized traffic
    for (int i = 0; i < 300; i++) drive(rand_stim());

    // Asynchronous reset mid-cycle with a valid instruction in EX
    s = idle(); s.valid = 1; s.rw = 1; s.rd = 3; s.op = 3'b101; s.rs1d = 32'h55;
    s.rs2d = 32'h66; s.rs1 = 1; s.rs2 = 2;
    drive(s);
    drive(idle());
    check("pre-reset valid", {31'd0, ex_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("async rst alu_op", {29'd0, alu_op}, 32'd0);
    check("async rst ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check("async rst alu_a", alu_a, 32'd0);
    check("async rst alu_b", alu_b, 32'd0);

    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", expq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
